// File: rtl/cpu_debug_host_shifter.sv
// -----------------------------------------------------------------------------
// cpu_debug_host_shifter
//
// Purpose:
//   JTAG-side initiator for the CPU debug slave. One parallel command (IR value
//   plus DR payload) is turned into the virtual-JTAG sequence
//   UIR -> CDR -> SDR x DR_WIDTH -> UDR -> RTI, with TCK generated as a divided
//   strobe of clk. The captured TDO word and the IR status seen during UIR are
//   returned over a valid/ready response channel.
//
// Parameters:
//   DR_WIDTH  shift length in bits (>= 1)
//   TCK_DIV   clk cycles per TCK half-period (>= 1); TCK period = 2*TCK_DIV
//
// Ports:
//   clk, reset_n                    system clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_ir, cmd_data                IR to load, DR payload (shifted LSB first)
//   rsp_valid/rsp_ready             response handshake
//   rsp_data                        TDO bits, bit k = bit sampled in SDR period k
//   rsp_ir_out                      vji_ir_out sampled at the UIR rising edge
//   vji_tck, vji_tdi, vji_tdo       generated TCK and serial data
//   vji_ir_in, vji_ir_out           current IR / slave IR status
//   vji_uir..vji_rti                one-hot virtual state flags
//
// Build option:
//   DEBUG_HOST_IR_CACHE_EN  when defined, UIR is skipped if the command IR
//                           matches the IR already loaded by a previous UIR.
//
// State table:
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   UIR   | one TCK period, vji_uir high, vji_ir_out captured on rising edge
//   CDR   | one TCK period, vji_cdr high, tdi held low
//   SDR   | DR_WIDTH TCK periods, one payload bit per period
//   UDR   | one TCK period, vji_udr high
//   RTI   | one TCK period, vji_rti high
//   RESP  | response presented until rsp_ready
// -----------------------------------------------------------------------------
module cpu_debug_host_shifter #(
    parameter int DR_WIDTH = 38,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [1:0]          rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [1:0]          vji_ir_in,
    input  logic [1:0]          vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int PH_W  = $clog2(2 * TCK_DIV);
    localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    // Phase down-counter: PH_LAST at the start of a period, 0 on its last cycle.
    // Values >= PH_HALF are the low half, values below it the high half.
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * TCK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(TCK_DIV);
    localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(TCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DR_WIDTH-1:0]   shift_q, shift_d;
    logic [1:0]            ir_q, ir_d;
    logic [DR_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]            rsp_ir_q, rsp_ir_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  ready_q;
`ifdef DEBUG_HOST_IR_CACHE_EN
    logic                  ir_valid_q, ir_valid_d;
`endif

    logic active;
    logic period_end;
    logic tck_rise;

    assign active     = (state_q == ST_UIR) || (state_q == ST_CDR) ||
                        (state_q == ST_SDR) || (state_q == ST_UDR) ||
                        (state_q == ST_RTI);
    assign period_end = (ph_q == '0);
    // First clk cycle of the high half: TDO and IR status are sampled here.
    assign tck_rise   = (ph_q == PH_RISE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ph_q        <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            ir_q        <= '0;
            rsp_data_q  <= '0;
            rsp_ir_q    <= '0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
`ifdef DEBUG_HOST_IR_CACHE_EN
            ir_valid_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            ir_q        <= ir_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ir_q    <= rsp_ir_d;
            rsp_valid_q <= rsp_valid_d;
            // Keeps cmd_ready low while reset is held, high from the next cycle.
            ready_q     <= 1'b1;
`ifdef DEBUG_HOST_IR_CACHE_EN
            ir_valid_q  <= ir_valid_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        ir_d        = ir_q;
        rsp_data_d  = rsp_data_q;
        rsp_ir_d    = rsp_ir_q;
        rsp_valid_d = 1'b0;
`ifdef DEBUG_HOST_IR_CACHE_EN
        ir_valid_d  = ir_valid_q;
`endif

        if (active) begin
            ph_d = period_end ? PH_LAST : ph_q - PH_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    shift_d = cmd_data;
                    bit_d   = BIT_LAST;
                    ph_d    = PH_LAST;
`ifdef DEBUG_HOST_IR_CACHE_EN
                    if (ir_valid_q && (cmd_ir == ir_q)) begin
                        state_d = ST_CDR;
                    end else begin
                        state_d    = ST_UIR;
                        ir_d       = cmd_ir;
                        ir_valid_d = 1'b1;
                    end
`else
                    state_d = ST_UIR;
                    ir_d    = cmd_ir;
`endif
                end
            end
            ST_UIR: begin
                if (tck_rise) begin
                    rsp_ir_d = vji_ir_out;
                end
                if (period_end) begin
                    state_d = ST_CDR;
                end
            end
            ST_CDR: begin
                if (period_end) begin
                    state_d = ST_SDR;
                end
            end
            ST_SDR: begin
                // Captured bits enter at the MSB; after DR_WIDTH periods the
                // bit from period k has moved down to position k.
                if (tck_rise) begin
                    rsp_data_d = DR_WIDTH'({vji_tdo, rsp_data_q} >> 1);
                end
                if (period_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == '0) begin
                        state_d = ST_UDR;
                    end else begin
                        bit_d = bit_q - BIT_W'(1);
                    end
                end
            end
            ST_UDR: begin
                if (period_end) begin
                    state_d = ST_RTI;
                end
            end
            ST_RTI: begin
                if (period_end) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // rsp_valid is registered: it rises one cycle after RESP entry.
                if (rsp_valid_q && rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready  = ready_q && (state_q == ST_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_ir_out = rsp_ir_q;

    assign vji_tck    = active && (ph_q < PH_HALF);
    assign vji_tdi    = (state_q == ST_SDR) && shift_q[0];
    assign vji_ir_in  = ir_q;
    assign vji_uir    = (state_q == ST_UIR);
    assign vji_cdr    = (state_q == ST_CDR);
    assign vji_sdr    = (state_q == ST_SDR);
    assign vji_udr    = (state_q == ST_UDR);
    assign vji_rti    = (state_q == ST_RTI);

endmodule

// File: doc/cpu_debug_host_shifter.md
Name: cpu_debug_host_shifter

Overview:
JTAG-side initiator for the CPU debug slave. It converts one parallel command (IR value plus DR payload) into the virtual-JTAG state and pulse sequence that the slave's TCK-domain logic consumes: UIR, CDR, SDR shifting, UDR, then RTI. It returns the captured TDO word and IR status over a valid/ready response channel. It runs on the system clock and generates TCK as a divided strobe, replacing the hard JTAG hub for in-fabric debug access and for bench stimulus.

Parameters:
DR_WIDTH, 38, shift length in bits; must be >= 1.
TCK_DIV, 2, clk cycles per TCK half-period; must be >= 1.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_ir  in  2  IR value to load
cmd_data  in  DR_WIDTH  DR payload, shifted LSB first
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_data  out  DR_WIDTH  captured TDO bits; bit k = bit sampled in shift period k
rsp_ir_out  out  2  vji_ir_out sampled during UIR period
vji_tck  out  1  generated TCK
vji_tdi  out  1  serial data to slave
vji_tdo  in  1  serial data from slave
vji_ir_in  out  2  current IR
vji_ir_out  in  2  slave IR status
vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state flags

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low, on reset_n.
- Reset, including mid-command: the FSM returns to IDLE. All outputs go to 0, including vji_ir_in, rsp_data and rsp_ir_out. cmd_ready goes to 1 on the first cycle after reset deasserts. An in-flight command is dropped and produces no response.
- TCK period is 2*TCK_DIV clk cycles.
  - Low half first, then high half.
  - vji_tck goes high on the first clk cycle of the high half.
- FSM states: IDLE, UIR, CDR, SDR, UDR, RTI, RESP.
  - Each of UIR, CDR, UDR and RTI lasts exactly one TCK period.
  - SDR lasts DR_WIDTH periods.
  - State and flag changes occur only at TCK period boundaries, i.e. with the falling edge.
- Accept: the handshake completes when cmd_valid && cmd_ready in IDLE.
  - cmd_ir and cmd_data are registered.
  - UIR begins on the next cycle with vji_tck low.
- UIR: vji_uir=1 and vji_ir_in=cmd_ir. vji_ir_in holds this value until the next UIR or reset. vji_ir_out is sampled at the UIR rising edge into rsp_ir_out.
- CDR: vji_cdr=1; vji_tdi=0.
- SDR period k (k=0..DR_WIDTH-1):
  - vji_sdr=1 and vji_tdi=cmd_data[k] for the whole period.
  - vji_tdo is sampled on the rising-edge clk cycle into rsp_data[k].
- UDR: vji_udr=1. RTI: vji_rti=1, vji_tck keeps toggling.
- Only one flag is high at a time; all flags are 0 in IDLE and RESP. vji_tck is 0 in IDLE and RESP.
- RESP: rsp_valid=1 with rsp_data and rsp_ir_out stable.
  - On rsp_valid && rsp_ready, the FSM goes to IDLE next cycle.
  - cmd_ready is 0 in that handshake cycle and 1 in the following cycle.
- cmd_ready=1 only in IDLE. cmd_valid outside IDLE is ignored.
- Latency: rsp_valid first rises (DR_WIDTH+4)*2*TCK_DIV+1 clk cycles after the accept edge. With defaults this is 169.

Optional Feature:
DEBUG_HOST_IR_CACHE_EN
- Defined:
  - A valid-IR flag is cleared by reset and set after the first UIR.
  - If the flag is set and cmd_ir equals the current vji_ir_in, UIR is skipped and the FSM goes straight from accept to CDR. Latency drops by one TCK period.
  - rsp_ir_out returns the value from the last executed UIR.
- Undefined: UIR is executed on every command. No cache register exists.

Test Plan:
- Reset, then idle 10 cycles -> all vji_* outputs 0, rsp_valid=0, cmd_ready=1.
- Defaults; cmd_ir=2'b01, cmd_data=38'h2A_5555_AAAA; slave model drives vji_tdo from 38'h15_0F0F_F0F0 LSB first; vji_ir_out=2'b10 -> vji_tdi serialises 38'h2A_5555_AAAA LSB first. Expected response: rsp_data=38'h15_0F0F_F0F0, rsp_ir_out=2'b10. rsp_valid rises at cycle 169 after accept. Flag order: UIR, CDR, 38×SDR, UDR, RTI, each one period wide.
- Hold rsp_ready=0 for 50 cycles with cmd_valid=1 -> rsp_valid and data stay stable, cmd_ready=0, no second UIR. Then rsp_ready=1 for 1 cycle -> cmd_ready=1 on the next cycle and the second command is accepted.
- Assert reset_n=0 for 1 cycle during SDR bit 20 -> all outputs 0 next cycle and no response. A new command then completes normally.
- TCK_DIV=1, DR_WIDTH=1, cmd_data=1 -> vji_tck toggles every clk cycle. rsp_valid rises at cycle 11. vji_tdi=1 for exactly 2 cycles during SDR.
- With DEBUG_HOST_IR_CACHE_EN: two commands with cmd_ir=2'b11 -> vji_uir pulses only for the first. The second response arrives 2*TCK_DIV cycles sooner. A third command with cmd_ir=2'b00 executes UIR.
